spi_master_ctrl: RTL and testbench

- Transaction controller for the SPI master write path; sits directly upstream of the 8-bit shift register (spi_shift).
- Accepts a start request, drives that register's load and shift_en strobes, generates SCLK and CS_n in mode 0 (CPOL=0, CPHA=0), and captures MISO into an 8-bit receive register.
- The shift register presents MOSI on its s_out, MSB first, sampling strobes on negedge clk; this block drives strobes from posedge clk.

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_master_ctrl_if.sv | 26 ++
 rtl/spi_clk_div.sv | 29 ++
 rtl/spi_shift.sv | 27 ++
 rtl/spi_master_ctrl.sv | 112 +++++++++++
 tb/tb_spi_master_ctrl.sv | 225 ++++++++++++++++++++++
 6 files changed

// File: rtl/spi_pkg.sv
// Shared constants and state encoding for the SPI master write path.
package spi_pkg;
  localparam int NBITS       = 8;
  localparam int CLK_DIV_DEF = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SETUP = 3'd2,
    S_XFER  = 3'd3,
    S_HOLD  = 3'd4,
    S_DONE  = 3'd5
  } spi_state_e;
endpackage

// File: rtl/spi_master_ctrl_if.sv
// Handshake and serial signals between the SPI transaction controller and its neighbours.
interface spi_master_ctrl_if;
  import spi_pkg::*;

  logic             start;
  logic [NBITS-2:0] tx_data;
  logic             miso;
  logic             load;
  logic             shift_en;
  logic             sclk;
  logic             cs_n;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] rx_data;
  logic             rx_valid;

  modport master (
    input  start, tx_data, miso,
    output load, shift_en, sclk, cs_n, busy, done, rx_data, rx_valid
  );

  modport slave (
    output start, tx_data, miso,
    input  load, shift_en, sclk, cs_n, busy, done, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period counter; phase_end marks the last clk cycle of each half-period.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic phase_end
);

  localparam logic [7:0] TC = 8'(CLK_DIV - 1);

  logic [7:0] cnt;

  assign phase_end = en && (cnt == TC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (!en || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/spi_shift.sv
// 8-bit MOSI shift register, MSB first; strobes are sampled on the falling clk edge.
module spi_shift
  import spi_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift_en,
  input  logic [NBITS-1:0] data_in,
  output logic             s_out
);

  logic [NBITS-1:0] sr;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else if (load) begin
      sr <= data_in;
    end else if (shift_en) begin
      sr <= {sr[NBITS-2:0], 1'b0};
    end
  end

  assign s_out = sr[NBITS-1];

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 transaction controller: frames one byte, strobes the MOSI shift register, captures MISO.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one cycle, shift register load strobe, CS asserted
// SETUP | CLK_DIV cycles, MOSI bit 7 settles before first SCLK rise
// XFER  | 8 bits, each a high then a low SCLK phase of CLK_DIV cycles
// HOLD  | CLK_DIV cycles, CS held after last falling edge
// DONE  | one cycle, CS released, done/rx_valid, rx_data updated
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF
) (
  input  logic            clk,
  input  logic            rst,
  spi_master_ctrl_if.master bus
);

  localparam logic [2:0] IDLE  = S_IDLE;
  localparam logic [2:0] LOAD  = S_LOAD;
  localparam logic [2:0] SETUP = S_SETUP;
  localparam logic [2:0] XFER  = S_XFER;
  localparam logic [2:0] HOLD  = S_HOLD;
  localparam logic [2:0] DONE  = S_DONE;
  localparam logic [2:0] LAST_BIT = 3'(NBITS - 1);

  logic [2:0]       state, state_nxt;
  logic [2:0]       bit_cnt, bit_cnt_nxt;
  logic             phase_lo, phase_lo_nxt;
  logic [NBITS-1:0] rx_shift;
  logic             div_en;
  logic             phase_end;
  logic             hi_end;

  assign div_en = (state == SETUP) || (state == XFER) || (state == HOLD);
  assign hi_end = (state == XFER) && phase_end && !phase_lo;

  spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (div_en),
    .phase_end (phase_end)
  );

  always_comb begin
    state_nxt    = state;
    bit_cnt_nxt  = bit_cnt;
    phase_lo_nxt = phase_lo;
    case (state)
      IDLE:  if (bus.start) state_nxt = LOAD;
      LOAD:  state_nxt = SETUP;
      SETUP: if (phase_end) begin
        state_nxt    = XFER;
        bit_cnt_nxt  = '0;
        phase_lo_nxt = 1'b0;
      end
      XFER:  if (phase_end) begin
        if (!phase_lo) begin
          phase_lo_nxt = 1'b1;
        end else if (bit_cnt == LAST_BIT) begin
          state_nxt    = HOLD;
          phase_lo_nxt = 1'b0;
        end else begin
          bit_cnt_nxt  = bit_cnt + 3'd1;
          phase_lo_nxt = 1'b0;
        end
      end
      HOLD:  if (phase_end) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with the state they describe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      phase_lo     <= 1'b0;
      rx_shift     <= '0;
      bus.load     <= 1'b0;
      bus.shift_en <= 1'b0;
      bus.sclk     <= 1'b0;
      bus.cs_n     <= 1'b1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.rx_data  <= '0;
    end else begin
      state        <= state_nxt;
      bit_cnt      <= bit_cnt_nxt;
      phase_lo     <= phase_lo_nxt;
      bus.load     <= (state_nxt == LOAD);
      bus.cs_n     <= (state_nxt == IDLE) || (state_nxt == DONE);
      bus.busy     <= (state_nxt != IDLE);
      bus.done     <= (state_nxt == DONE);
      bus.rx_valid <= (state_nxt == DONE);
      bus.sclk     <= (state_nxt == XFER) && !phase_lo_nxt;
      bus.shift_en <= hi_end && (bit_cnt != LAST_BIT);
      if (state == LOAD) begin
        rx_shift <= '0;
      end else if (hi_end) begin
        rx_shift <= {rx_shift[NBITS-2:0], bus.miso};
      end
      if (state_nxt == DONE) begin
        bus.rx_data <= rx_shift;
      end
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl at CLK_DIV 2, 1 and 255, with the MOSI shift register attached.
module tb_spi_master_ctrl;
  import spi_pkg::*;

  logic clk;
  logic rst;
  logic mosi;
  logic [7:0] sl_pat;
  logic [2:0] sl_idx;
  int cyc;
  int n_chk;
  int n_err;

  spi_master_ctrl_if a_if ();
  spi_master_ctrl_if b_if ();
  spi_master_ctrl_if c_if ();

  spi_master_ctrl #(.CLK_DIV(2))   u_dut_a (.clk(clk), .rst(rst), .bus(a_if));
  spi_master_ctrl #(.CLK_DIV(1))   u_dut_b (.clk(clk), .rst(rst), .bus(b_if));
  spi_master_ctrl #(.CLK_DIV(255)) u_dut_c (.clk(clk), .rst(rst), .bus(c_if));

  spi_shift u_shift (
    .clk      (clk),
    .rst      (rst),
    .load     (a_if.load),
    .shift_en (a_if.shift_en),
    .data_in  ({1'b0, a_if.tx_data}),
    .s_out    (mosi)
  );

  // Slave: presents pattern MSB first, advancing on each SCLK falling edge.
  always @(negedge a_if.sclk or posedge rst) begin
    if (rst) sl_idx <= 3'd0;
    else     sl_idx <= sl_idx + 3'd1;
  end
  assign a_if.miso = sl_pat[3'd7 - sl_idx];
  assign b_if.miso = 1'b1;
  assign c_if.miso = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic frame_a(input logic [6:0] tx, input logic [7:0] exp_rx,
                         input logic [7:0] prev_rx, input int pulse_k);
    int load_n, load_k, cs_lo_n, cs_first, cs_last, done_n, done_k, rv_n;
    int shen_n, both_n, busy_bad, rise_n, first_rise, last_rise, gap_bad, hi_n;
    logic [7:0] mosi_bits;
    logic [7:0] rx_at_done;
    logic sclk_q;
    load_n = 0; load_k = -1; cs_lo_n = 0; cs_first = -1; cs_last = -1;
    done_n = 0; done_k = -1; rv_n = 0; shen_n = 0; both_n = 0; busy_bad = 0;
    rise_n = 0; first_rise = -1; last_rise = 0; gap_bad = 0; hi_n = 0;
    mosi_bits = '0; rx_at_done = '0; sclk_q = 1'b0;
    @(posedge clk); #1;
    a_if.start = 1'b1;
    a_if.tx_data = tx;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (a_if.load) begin load_n++; load_k = k; end
      if (!a_if.cs_n) begin
        cs_lo_n++;
        if (cs_first < 0) cs_first = k;
        cs_last = k;
      end
      if (a_if.done) begin done_n++; done_k = k; rx_at_done = a_if.rx_data; end
      if (a_if.rx_valid) rv_n++;
      if (a_if.shift_en) shen_n++;
      if (a_if.load && a_if.shift_en) both_n++;
      if (a_if.busy !== ((k >= 1) && (k <= 38))) busy_bad++;
      if (a_if.sclk) hi_n++;
      if (a_if.sclk && !sclk_q) begin
        if (rise_n < 8) mosi_bits[7 - rise_n] = mosi;
        if (rise_n == 0) first_rise = k;
        else if (k - last_rise != 4) gap_bad++;
        last_rise = k;
        rise_n++;
      end
      if (k == 20) chk("rx_hold_mid", a_if.rx_data, prev_rx);
      sclk_q = a_if.sclk;
      @(posedge clk); #1;
      if (k == 0) a_if.start = 1'b0;
      if (k == pulse_k) a_if.start = 1'b1;
      if (k == pulse_k + 1) a_if.start = 1'b0;
      if (k >= 2) a_if.tx_data = ~tx;
    end
    chk("load_cycle", load_k, 1);
    chk("load_count", load_n, 1);
    chk("cs_first", cs_first, 1);
    chk("cs_last", cs_last, 37);
    chk("cs_low_cycles", cs_lo_n, 37);
    chk("done_cycle", done_k, 38);
    chk("done_count", done_n, 1);
    chk("rx_valid_count", rv_n, 1);
    chk("busy_window", busy_bad, 0);
    chk("sclk_rises", rise_n, 8);
    chk("sclk_first_rise", first_rise, 4);
    chk("sclk_period", gap_bad, 0);
    chk("sclk_high_cycles", hi_n, 16);
    chk("shift_en_count", shen_n, 7);
    chk("load_shift_overlap", both_n, 0);
    chk("mosi_bits", mosi_bits, {1'b0, tx});
    chk("rx_data_done", rx_at_done, exp_rx);
    chk("rx_hold_after", a_if.rx_data, exp_rx);
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    cyc = 0;
    n_chk = 0;
    n_err = 0;
    sl_pat = 8'hA3;
    a_if.start = 1'b0; a_if.tx_data = '0;
    b_if.start = 1'b0; b_if.tx_data = '0;
    c_if.start = 1'b0; c_if.tx_data = '0;
    #12;
    chk("rst_cs_n", a_if.cs_n, 1);
    chk("rst_sclk", a_if.sclk, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_load_shift_done", {a_if.load, a_if.shift_en, a_if.done, a_if.rx_valid}, 0);
    chk("rst_rx_data", a_if.rx_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    frame_a(7'h55, 8'hA3, 8'h00, -1);
    sl_pat = 8'h5C;
    frame_a(7'h2A, 8'h5C, 8'hA3, 15);

    // Reset during the high phase of bit 4 (cycles 20..21 for CLK_DIV=2).
    sl_pat = 8'hA3;
    @(posedge clk); #1;
    a_if.start = 1'b1;
    a_if.tx_data = 7'h33;
    @(posedge clk); #1;
    a_if.start = 1'b0;
    repeat (20) @(posedge clk);
    #2;
    chk("pre_rst_sclk", a_if.sclk, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_cs_n", a_if.cs_n, 1);
    chk("mid_rst_sclk", a_if.sclk, 0);
    chk("mid_rst_busy", a_if.busy, 0);
    chk("mid_rst_rx_data", a_if.rx_data, 0);
    chk("mid_rst_strobes", {a_if.load, a_if.shift_en, a_if.done}, 0);
    @(negedge clk);
    rst = 1'b0;
    frame_a(7'h33, 8'hA3, 8'h00, -1);

    // CLK_DIV=1, start held high: frames every 21 cycles.
    begin
      int dn, d0, d1, d2, hi_n, first_rise;
      logic sclk_q;
      dn = 0; d0 = -1; d1 = -1; d2 = -1; hi_n = 0; first_rise = -1; sclk_q = 1'b0;
      @(posedge clk); #1;
      b_if.start = 1'b1;
      for (int k = 0; k <= 62; k++) begin
        @(negedge clk);
        if (b_if.done) begin
          if (dn == 0) d0 = k;
          if (dn == 1) d1 = k;
          if (dn == 2) d2 = k;
          dn++;
        end
        if (k <= 20 && b_if.sclk) hi_n++;
        if (b_if.sclk && !sclk_q && first_rise < 0) first_rise = k;
        sclk_q = b_if.sclk;
        @(posedge clk); #1;
      end
      b_if.start = 1'b0;
      chk("b2b_done_first", d0, 20);
      chk("b2b_spacing_1", d1 - d0, 21);
      chk("b2b_spacing_2", d2 - d1, 21);
      chk("b2b_done_count", dn, 3);
      chk("div1_first_rise", first_rise, 3);
      chk("div1_high_cycles", hi_n, 8);
      chk("div1_rx_data", b_if.rx_data, 8'hFF);
      repeat (5) @(posedge clk);
      #1;
      chk("b2b_idle_busy", b_if.busy, 0);
    end

    // CLK_DIV=255, longest SCLK half-period.
    begin
      int dn, done_k, hi_n, first_rise, first_fall;
      logic sclk_q;
      logic busy_after;
      dn = 0; done_k = -1; hi_n = 0; first_rise = -1; first_fall = -1;
      sclk_q = 1'b0; busy_after = 1'b1;
      @(posedge clk); #1;
      c_if.start = 1'b1;
      c_if.tx_data = 7'h7F;
      for (int k = 0; k <= 4595; k++) begin
        @(negedge clk);
        if (c_if.done) begin dn++; done_k = k; end
        if (c_if.sclk) hi_n++;
        if (c_if.sclk && !sclk_q && first_rise < 0) first_rise = k;
        if (!c_if.sclk && sclk_q && first_fall < 0) first_fall = k;
        if (k == 4593) busy_after = c_if.busy;
        sclk_q = c_if.sclk;
        @(posedge clk); #1;
        if (k == 0) c_if.start = 1'b0;
      end
      chk("div255_done_cycle", done_k, 4592);
      chk("div255_done_count", dn, 1);
      chk("div255_first_rise", first_rise, 257);
      chk("div255_half_period", first_fall - first_rise, 255);
      chk("div255_high_cycles", hi_n, 2040);
      chk("div255_busy_after", busy_after, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
